// File: rtl/apb_mst_pkg.sv
// apb_mst_pkg
//   Shared types and default constants for the APB requester bridge.
//   - apb_state_e        : transfer FSM state (IDLE / SETUP / ACCESS)
//   - ADDR_W_DEF         : default paddr / cmd_addr width
//   - DATA_W_DEF         : default data bus width
//   - TIMEOUT_CYC_DEF    : default wait-state limit (APB_MST_TIMEOUT_EN builds)
package apb_mst_pkg;

  localparam int unsigned ADDR_W_DEF      = 13;
  localparam int unsigned DATA_W_DEF      = 32;
  localparam int unsigned TIMEOUT_CYC_DEF = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_mst_wdog.sv
// apb_mst_wdog
//   Wait-state watchdog for the APB requester. Counts the wait cycles seen
//   in ACCESS and flags expiry on the wait cycle that reaches TIMEOUT_CYC.
//   Only instantiated when APB_MST_TIMEOUT_EN is defined.
// Ports
//   clk, reset  : clock, async active-high reset
//   clr_i       : restart the count (asserted on SETUP entry)
//   wait_i      : this clk edge is a pclken-qualified ACCESS cycle with pready=0
//   expire_o    : this wait cycle is the TIMEOUT_CYC-th one; abort the transfer
module apb_mst_wdog
  import apb_mst_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic wait_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of wait cycles already elapsed, so the cycle
  // being evaluated now is number cnt_q+1.
  assign expire_o = wait_i && (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (wait_i && !expire_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge
//   Converts a valid/ready command stream into single APB transfers and
//   returns one valid/ready response per command. APB phases advance only
//   on clk edges with pclken=1; the response handshake runs at full clk rate.
//   Optional build macro APB_MST_TIMEOUT_EN adds a wait-state watchdog that
//   aborts a transfer after TIMEOUT_CYC wait cycles (rsp_err=rsp_timeout=1).
// Ports
//   clk, reset              : clock, async active-high reset
//   pclken                  : APB clock enable
//   cmd_valid/ready/write/addr/wdata : command channel
//   rsp_valid/ready/rdata/err/timeout : response channel
//   psel, penable, pwrite, paddr, pwdata, prdata, pready, pslverr : APB
//   idle                    : no transfer or response pending
//   INT                     : one-cycle pulse when an error response appears
module apb_master_bridge
  import apb_mst_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pclken,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic              idle,
  output logic              INT
);

  apb_state_e        state_q, state_d;
  logic              psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              int_q, int_d;
  logic              accept, timeout_hit;

  // reset is folded in so cmd_ready is low throughout reset even with pclken=1.
  assign cmd_ready = (state_q == IDLE) && !rsp_valid_q && pclken && !reset;
  assign accept    = cmd_valid && cmd_ready;

`ifdef APB_MST_TIMEOUT_EN
  logic rsp_to_q, rsp_to_d;

  apb_mst_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (accept),
    .wait_i   (pclken && (state_q == ACCESS) && !pready),
    .expire_o (timeout_hit)
  );

  assign rsp_timeout = rsp_to_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    int_d       = 1'b0;
`ifdef APB_MST_TIMEOUT_EN
    rsp_to_d    = rsp_to_q;
`endif

    // Response consumption runs at clk rate, independent of pclken.
    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_write ? cmd_wdata : '0;
        end
      end
      SETUP: begin
        if (pclken) begin
          state_d   = ACCESS;
          penable_d = 1'b1;
        end
      end
      ACCESS: begin
        // pready/pslverr only matter on pclken edges; completion wins over
        // a watchdog expiry landing on the same cycle.
        if (pclken && pready) begin
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = pslverr;
          int_d       = pslverr;
`ifdef APB_MST_TIMEOUT_EN
          rsp_to_d    = 1'b0;
`endif
        end else if (timeout_hit) begin
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          int_d       = 1'b1;
`ifdef APB_MST_TIMEOUT_EN
          rsp_to_d    = 1'b1;
`endif
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      int_q       <= 1'b0;
`ifdef APB_MST_TIMEOUT_EN
      rsp_to_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      int_q       <= int_d;
`ifdef APB_MST_TIMEOUT_EN
      rsp_to_q    <= rsp_to_d;
`endif
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign INT       = int_q;
  assign idle      = (state_q == IDLE) && !rsp_valid_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge
//   Directed and randomized transfers against apb_master_bridge. The bench
//   plays the APB completer (inserting a chosen number of wait states) and
//   predicts each response from the transfer parameters alone.
//   Honours APB_MST_TIMEOUT_EN when predicting watchdog aborts.
module tb_apb_master_bridge;

  localparam int AW   = 13;
  localparam int DW   = 32;
  localparam int TCYC = 4;
`ifdef APB_MST_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pclken = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b0;
  logic          pslverr = 1'b0;

  logic          cmd_ready, rsp_valid, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata, pwdata;
  logic          psel, penable, pwrite, idle, INT;
  logic [AW-1:0] paddr;

  int total = 0;
  int bad   = 0;

  apb_master_bridge #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TCYC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pclken      (pclken),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr),
    .idle        (idle),
    .INT         (INT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete command/response transaction with the bench acting as
  // completer. The expected result is derived purely from the parameters:
  // a transfer needs 1 setup edge + waits + 1 completing edge, unless the
  // watchdog is built in and waits reaches TCYC, in which case the TCYC-th
  // wait edge ends it.
  task automatic xfer(input string nm, input bit wr, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input int waits,
                      input logic [DW-1:0] rdata, input bit err, input bit tgl,
                      input int hold);
    bit            exp_to, exp_err, got, hold_bad, acc;
    int            exp_edges, psel_edges, en_edges, wait_edges;
    logic [DW-1:0] exp_rd, exp_wd;
    exp_to     = TO_EN && (waits >= TCYC);
    exp_edges  = exp_to ? (TCYC + 1) : (waits + 2);
    exp_rd     = (exp_to || wr) ? '0 : rdata;
    exp_wd     = wr ? wdata : '0;
    exp_err    = exp_to || err;
    got        = 1'b0;
    hold_bad   = 1'b0;
    psel_edges = 0;
    en_edges   = 0;
    wait_edges = 0;

    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    for (int cyc = 0; cyc < 3000 && !got; cyc++) begin
      pclken = tgl ? ((cyc % 2) == 0) : 1'b1;
      if (psel && penable && pclken) begin
        pready  = (wait_edges == waits);
        pslverr = pready ? err : 1'($urandom);
        prdata  = pready ? rdata : DW'($urandom);
      end else begin
        // Outside a pclken ACCESS cycle these must be ignored: make them noisy.
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
        prdata  = DW'($urandom);
      end
      #1;
      acc = cmd_valid && cmd_ready;
      if (psel && (paddr !== addr || pwrite !== wr || pwdata !== exp_wd)) hold_bad = 1'b1;
      if (psel && pclken) psel_edges++;
      if (penable && pclken) en_edges++;
      if (psel && penable && pclken && !pready) wait_edges++;
      @(posedge clk);
      #1;
      if (acc) cmd_valid = 1'b0;
      got = rsp_valid;
      if (!got) @(negedge clk);
    end
    pready  = 1'b0;
    pslverr = 1'b0;

    chk({nm, "_done"},    got, 1);
    chk({nm, "_rdata"},   rsp_rdata, exp_rd);
    chk({nm, "_err"},     rsp_err, exp_err);
    chk({nm, "_timeout"}, rsp_timeout, exp_to);
    chk({nm, "_int"},     INT, exp_err);
    chk({nm, "_psel0"},   {psel, penable}, 2'b00);
    chk({nm, "_idle"},    idle, 0);
    chk({nm, "_selcyc"},  psel_edges, exp_edges);
    chk({nm, "_encyc"},   en_edges, exp_edges - 1);
    chk({nm, "_stable"},  hold_bad, 0);
    $display("xfer %s wr=%0d addr=%0h waits=%0d tgl=%0d rdata=%0h err=%0d to=%0d",
             nm, wr, addr, waits, tgl, rsp_rdata, rsp_err, rsp_timeout);

    // Offer a new command while the response is pending: it must stall.
    @(negedge clk);
    pclken    = 1'b1;
    cmd_valid = 1'b1;
    cmd_addr  = AW'($urandom);
    for (int i = 0; i <= hold; i++) begin
      #1;
      chk({nm, "_stall"}, cmd_ready, 0);
      @(posedge clk);
      #1;
      chk({nm, "_hold"}, {rsp_valid, rsp_rdata, rsp_err}, {1'b1, exp_rd, exp_err});
      if (i == 0) chk({nm, "_int1"}, INT, 0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({nm, "_rspclr"}, rsp_valid, 0);
    chk({nm, "_idle1"},  idle, 1);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    // Reset state, with pclken and cmd_valid already high.
    pclken    = 1'b1;
    cmd_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_apb",  {psel, penable, pwrite, paddr, pwdata}, '0);
    chk("rst_rsp",  {rsp_valid, rsp_rdata, rsp_err, rsp_timeout, INT}, '0);
    chk("rst_idle", idle, 1);
    chk("rst_rdy",  cmd_ready, 0);
    cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // cmd_ready follows pclken in IDLE.
    @(negedge clk);
    pclken = 1'b0;
    #1;
    chk("rdy_pclk0", cmd_ready, 0);
    pclken = 1'b1;
    #1;
    chk("rdy_pclk1", cmd_ready, 1);

    // Directed transfers.
    xfer("wr_basic", 1'b1, 13'h010,  32'hDEADBEEF, 0, 32'h0BAD_F00D, 1'b0, 1'b0, 1);
    xfer("rd_wait3", 1'b0, 13'h1FFC, 32'h1234_5678, 3, 32'hA5A5_0001, 1'b0, 1'b0, 0);
    xfer("rd_tgl",   1'b0, 13'h1FFC, 32'h1234_5678, 3, 32'hA5A5_0001, 1'b0, 1'b1, 0);
    xfer("rd_slverr",1'b0, 13'h0040, 32'h0, 1, 32'h7777_1111, 1'b1, 1'b0, 3);
    xfer("wr_slverr",1'b1, 13'h0044, 32'hCAFE_0002, 0, 32'h0, 1'b1, 1'b0, 1);
    xfer("rd_wtm1",  1'b0, 13'h0100, 32'h0, TCYC - 1, 32'h0102_0304, 1'b0, 1'b0, 0);
    xfer("rd_wt",    1'b0, 13'h0104, 32'h0, TCYC, 32'h0506_0708, 1'b0, 1'b0, 0);
    xfer("rd_long",  1'b0, 13'h0ABC, 32'h0, 1000, 32'h1357_9BDF, 1'b0, 1'b0, 0);

    // Randomized transfers.
    for (int n = 0; n < 16; n++) begin
      xfer($sformatf("rnd%0d", n), 1'($urandom), AW'($urandom), $urandom,
           int'($urandom_range(0, 5)), $urandom, 1'($urandom), 1'($urandom),
           int'($urandom_range(0, 3)));
    end

    // Reset in the middle of ACCESS.
    @(negedge clk);
    pclken    = 1'b1;
    pready    = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 13'h0AA;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_access", {psel, penable}, 2'b11);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_apb",  {psel, penable}, 2'b00);
    chk("mid_rst_idle", idle, 1);
    chk("mid_rst_rsp",  rsp_valid, 0);
    chk("mid_rst_rdy",  cmd_ready, 0);
    @(negedge clk);
    reset  = 1'b0;
    pready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("post_rst", {rsp_valid, psel, penable, idle}, 4'b0001);
    end
    $display("xfer mid_reset done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
